// File: rtl/lsu_memory_master_if.sv
// Bus bundle between the load/store initiator, the core request side and the
// word-organised data memory.
interface lsu_memory_master_if;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        mem_store;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req, is_store, funct3, addr, wdata, mem_rdata,
    output busy, done, rdata, misaligned, mem_store, mem_address, mem_wdata
  );

  modport slave (
    output req, is_store, funct3, addr, wdata, mem_rdata,
    input  busy, done, rdata, misaligned, mem_store, mem_address, mem_wdata
  );
endinterface

// File: rtl/lsu_memory_master.sv
// Load/store initiator: turns one byte/half/word core request into word-wide
// memory accesses, with read-modify-write for sub-word stores.
module lsu_memory_master #(
  parameter int WORD_ADDR_BITS = 7
) (
  input  logic                clk,
  input  logic                reset,
  lsu_memory_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misaligned_q, misaligned_d;
  logic        mem_store_q, mem_store_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  function automatic logic is_legal(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (a[0] == 1'b0);
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !st;
      3'b101:  ok = !st && (a[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    case (f3)
      3'b000:  m[{lane, 3'b000} +: 8] = wd[7:0];
      3'b001:  m[{lane[1], 4'b0000} +: 16] = wd;
      default: m = word;
    endcase
    return m;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    misaligned_d  = misaligned_q;
    rdata_d       = rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          is_store_d    = bus.is_store;
          funct3_d      = bus.funct3;
          lane_d        = bus.addr[1:0];
          wdata_d       = bus.wdata[15:0];
          mem_address_d = 32'(bus.addr[WORD_ADDR_BITS+1:2]);
          mem_wdata_d   = bus.wdata;
          misaligned_d  = !is_legal(bus.is_store, bus.funct3, bus.addr[1:0]);
          if (!is_legal(bus.is_store, bus.funct3, bus.addr[1:0])) begin
            state_d = S_DONE;
          end else if (bus.is_store && (bus.funct3 == 3'b010)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (is_store_q) begin
          mem_wdata_d = store_merge(funct3_q, lane_q, bus.mem_rdata, wdata_q);
          state_d     = S_WRITE;
        end else begin
          rdata_d = load_format(funct3_q, lane_q, bus.mem_rdata);
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered copies of the state being entered.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_store_d = (state_d == S_WRITE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'd0;
      lane_q        <= 2'd0;
      wdata_q       <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      misaligned_q  <= 1'b0;
      mem_store_q   <= 1'b0;
      rdata_q       <= 32'd0;
      mem_address_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      is_store_q    <= is_store_d;
      funct3_q      <= funct3_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      misaligned_q  <= misaligned_d;
      mem_store_q   <= mem_store_d;
      rdata_q       <= rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.mem_store   = mem_store_q;
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_memory_master.sv
// Directed plus random bench for lsu_memory_master against a byte-level
// memory model and access rules evaluated with plain arithmetic.
module tb_lsu_memory_master;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  lsu_memory_master_if bif ();

  lsu_memory_master #(.WORD_ADDR_BITS(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory emulation: combinational read, write on clock edge, plus preload port.
  logic [31:0] mem [0:127];
  logic        pl_en;
  logic [6:0]  pl_idx;
  logic [31:0] pl_data;
  assign bif.mem_rdata = mem[bif.mem_address[6:0]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bif.mem_store) mem[bif.mem_address[6:0]] <= bif.mem_wdata;
  end

  // Reference state.
  logic [7:0]  ref_bytes [0:511];
  logic [31:0] exp_rdata;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  task automatic preload(input int idx, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 7'(idx); pl_data = w;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4+i] = w[i*8 +: 8];
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request through the DUT, checked against the reference rules.
  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic hold);
    int nbytes, base, lat, nst, exp_lat;
    logic legal;
    logic [31:0] st_addr, st_data, v;
    longint val;
    nbytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    legal  = (nbytes != 0) && ((a % nbytes) == 0) && !(st && f3 >= 3'd4);
    base   = int'(a % 512);
    if (!legal) exp_lat = 1;
    else if (st && nbytes < 4) exp_lat = 3;
    else exp_lat = 2;
    if (legal && !st) begin
      val = 0;
      for (int i = 0; i < nbytes; i++) val = val + (longint'(ref_bytes[base+i]) << (8*i));
      if (f3 < 3'd4 && nbytes < 4 && val >= (longint'(1) << (8*nbytes-1)))
        val = val - (longint'(1) << (8*nbytes));
      exp_rdata = 32'(val);
    end
    if (legal && st) begin
      v = wd;
      for (int i = 0; i < nbytes; i++) ref_bytes[base+i] = v[i*8 +: 8];
    end
    @(negedge clk);
    bif.req = 1'b1; bif.is_store = st; bif.funct3 = f3; bif.addr = a; bif.wdata = wd;
    lat = 0; nst = 0; st_addr = 32'd0; st_data = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (!hold) bif.req = 1'b0;
      if (bif.mem_store) begin nst++; st_addr = bif.mem_address; st_data = bif.mem_wdata; end
      if (bif.done) begin lat = k; break; end
    end
    bif.req = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " misaligned"}, {31'd0, bif.misaligned}, {31'd0, !legal});
    check({tag, " busy@done"}, {31'd0, bif.busy}, 32'd1);
    check({tag, " rdata"}, bif.rdata, exp_rdata);
    check({tag, " store_count"}, 32'(nst), (legal && st) ? 32'd1 : 32'd0);
    if (legal && st) begin
      check({tag, " store_addr"}, st_addr, (a >> 2) & 32'd127);
      check({tag, " store_data"}, st_data, ref_word(base / 4));
    end
    @(posedge clk); #1;
    check({tag, " idle"}, {30'd0, bif.busy, bif.done}, 32'd0);
    check({tag, " no_restart"}, {31'd0, bif.mem_store}, 32'd0);
  endtask

  initial begin
    int bad;
    errors = 0; checks = 0;
    pl_en = 1'b0; pl_idx = 7'd0; pl_data = 32'd0;
    bif.req = 1'b0; bif.is_store = 1'b0; bif.funct3 = 3'd0; bif.addr = 32'd0; bif.wdata = 32'd0;
    exp_rdata = 32'd0;
    reset = 1'b0;
    for (int i = 0; i < 128; i++) preload(i, $urandom);
    #1;
    check("reset busy", {31'd0, bif.busy}, 32'd0);
    check("reset done", {31'd0, bif.done}, 32'd0);
    check("reset rdata", bif.rdata, 32'd0);
    check("reset mem_address", bif.mem_address, 32'd0);
    @(negedge clk); reset = 1'b1;

    preload(1, 32'h0000_8610);
    do_op("LW4", 1'b0, 3'd2, 32'h4, 32'd0, 1'b0);
    do_op("LB4", 1'b0, 3'd0, 32'h4, 32'd0, 1'b0);
    do_op("LH4", 1'b0, 3'd1, 32'h4, 32'd0, 1'b0);
    check("LH4 value", bif.rdata, 32'hFFFF_8610);
    do_op("LHU4", 1'b0, 3'd5, 32'h4, 32'd0, 1'b0);
    preload(3, 32'h0000_0193);
    do_op("SB_D", 1'b1, 3'd0, 32'hD, 32'h0000_00AB, 1'b0);
    check("SB_D mem", mem[3], 32'h0000_AB93);
    do_op("SW10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
    do_op("LW10", 1'b0, 3'd2, 32'h10, 32'd0, 1'b0);
    check("LW10 value", bif.rdata, 32'hDEAD_BEEF);
    do_op("LW6", 1'b0, 3'd2, 32'h6, 32'd0, 1'b0);
    do_op("SH3", 1'b1, 3'd1, 32'h3, 32'h1234_5678, 1'b0);
    do_op("LWwrap", 1'b0, 3'd2, 32'h200, 32'd0, 1'b0);
    do_op("SHhi", 1'b1, 3'd1, 32'h22, 32'hCAFE_F00D, 1'b0);
    do_op("LBUf", 1'b1, 3'd4, 32'h8, 32'd0, 1'b0);

    // Reset during the READ cycle of a sub-word store.
    @(negedge clk);
    bif.req = 1'b1; bif.is_store = 1'b1; bif.funct3 = 3'd0; bif.addr = 32'h21; bif.wdata = 32'h55;
    @(posedge clk); #1;
    bif.req = 1'b0;
    check("rst_mid busy", {31'd0, bif.busy}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid outputs", {bif.busy, bif.done, bif.misaligned, bif.mem_store}, 32'd0);
    check("rst_mid rdata", bif.rdata, 32'd0);
    check("rst_mid mem_address", bif.mem_address, 32'd0);
    check("rst_mid mem_wdata", bif.mem_wdata, 32'd0);
    exp_rdata = 32'd0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid no write", mem[8], ref_word(8));
    do_op("LWpost", 1'b0, 3'd2, 32'h20, 32'd0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)));
    end

    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_word(i)) bad++;
    check("final memory", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_memory_master.md
Name: lsu_memory_master

Overview:
- Load/store initiator between the multi-cycle core and the word-organised data memory.
- Accepts one byte, half-word or word load/store request from the core.
- Converts the byte address to a word index and drives the memory's store/address/write-data inputs.
- Formats loaded data with sign or zero extension; sub-word stores use a read-modify-write sequence, because the memory writes whole words only.

Parameters:
- WORD_ADDR_BITS, 7: number of word-index bits the memory decodes; mem_address bits above this are driven 0.

Ports:
- clk  input  1  core clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  core request; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load; sampled with req.
- funct3  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data, low bytes used for sub-word; sampled with req.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  formatted load result; holds until the next load completes.
- misaligned  output  1  error flag, valid while done=1.
- mem_store  output  1  connects to the memory's store_instruction.
- mem_address  output  32  word index = addr[WORD_ADDR_BITS+1:2], zero-extended.
- mem_wdata  output  32  connects to the memory's data_memory_in.
- mem_rdata  input  32  connects to the memory's data_memory_out; combinational read of mem_address.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; busy, done, misaligned, mem_store = 0; rdata, mem_address, mem_wdata = 0. Reset mid-operation aborts the access and issues no memory write after that edge.
- Request latch: in IDLE, req==1 at a posedge latches is_store, funct3, addr and wdata. Core-side inputs are ignored while busy or done.
- States: IDLE, READ, WRITE, DONE.
- IDLE transitions:
  - Illegal request -> DONE with misaligned=1, no memory access. Illegal means funct3 not listed, store with funct3 100/101, half access with addr[0]=1, or word access with addr[1:0]!=0.
  - SW -> WRITE.
  - Any load, SB or SH -> READ.
- READ (1 cycle): mem_address driven, mem_store=0; mem_rdata is captured at the end of the cycle.
  - Load: rdata <= formatted data, then -> DONE.
  - Sub-word store: merge register <= captured word with the target lane replaced, then -> WRITE.
- Load formatting:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it; LW passes the word through.
- Sub-word store merge:
  - SB replaces byte addr[1:0] with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other bytes keep their captured value.
- WRITE (1 cycle): mem_store=1; mem_address = word index; mem_wdata = wdata (SW) or the merged word (SB/SH); -> DONE.
- mem_store is high only in WRITE: exactly one write cycle per legal store, none for loads or illegal requests.
- DONE (1 cycle): done=1, misaligned valid, busy=1; -> IDLE. misaligned clears on the next request.
- Latency, from the req-sampling edge to done high:
  - Illegal request: 1 cycle.
  - LW/LB/LH/LBU/LHU and SW: 2 cycles.
  - SB/SH: 3 cycles.
- Back-to-back: a new req can be accepted on the edge that leaves DONE at the earliest, i.e. the first IDLE cycle.
- Wrap-around: word-index bits above WORD_ADDR_BITS+1 of addr are dropped. Example: addr 0x00000200 with WORD_ADDR_BITS=7 maps to index 0, with no error.
- mem_address holds its last value in IDLE and DONE. mem_wdata is don't-care when mem_store=0.

Test Plan:
1. Preload mem[1]=0x00008610; LW addr 0x4 -> done 2 cycles after req, rdata=0x00008610, misaligned=0, mem_store never high.
2. Same memory; LB addr 0x4 -> rdata=0x00000010. LH addr 0x4 -> rdata=0xFFFF8610. LHU addr 0x4 -> rdata=0x00008610.
3. Preload mem[3]=0x00000193; SB addr 0xD wdata 0xAB -> one mem_store pulse with mem_address=3, mem_wdata=0x0000AB93; done at cycle 3.
4. SW addr 0x10 wdata 0xDEADBEEF -> single mem_store cycle with mem_address=4; a following LW addr 0x10 returns 0xDEADBEEF. A req held high during busy is accepted only once.
5. Illegal requests: LW addr 0x6 and SH addr 0x3 -> done after 1 cycle, misaligned=1, no mem_store, rdata unchanged from its previous value.
6. Assert reset low during the READ state of an SB -> next cycle IDLE, all outputs 0, no memory write occurs; a new LW then completes normally.
